// File: rtl/uart_pkg.sv
// Shared types, frame constants and parity helper for the UART Tx sequencer.
// Defining UART_TX_TWO_STOP_EN selects two stop bits; the default is one.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    STOP
  } tx_state_t;

  localparam int FRAME_BITS = 11;

`ifdef UART_TX_TWO_STOP_EN
  localparam int STOP_BITS = 2;
`else
  localparam int STOP_BITS = 1;
`endif

  // Tick index that opens the first stop period, and the last tick of the frame.
  localparam logic [3:0] FIRST_STOP_TICK = 4'(FRAME_BITS - 1);
  localparam logic [3:0] LAST_TICK       = 4'(FRAME_BITS + STOP_BITS - 2);

  function automatic logic [8:0] parity9(input logic [7:0] data, input logic odd);
    return {(^data) ^ odd, data};
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: start forces an immediate tick, then one tick per CLKS_PER_BIT clks.
// Tick is registered; mute suppresses a tick while still wrapping the counter.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  input  logic start,
  input  logic mute,
  output logic tick,
  output logic wrap
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign wrap = enable && (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (start) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else if (clear) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (enable) begin
      tick <= wrap && !mute;
      cnt  <= wrap ? '0 : cnt + 1'b1;
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART Tx sequencer: accepts a byte when idle, drives load/baud tick to the PISO, one frame per byte.
// Accept-to-load latency 1 clk; o_ready low for the whole frame. UART_TX_TWO_STOP_EN adds a stop bit.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_busy,
  output logic       o_baud_tick,
  output logic       o_load,
  output logic [8:0] o_load_data,
  output logic       o_frame_done
);

  tx_state_t  state;
  logic [3:0] bit_cnt;
  logic       accept;
  logic       wrap;
  logic       mute;
  logic       in_idle;

  assign accept  = i_valid && o_ready;
  assign in_idle = (state == IDLE);
  // The wrap that would start a period after the last stop bit only closes the frame.
  assign mute    = (state == STOP) && (bit_cnt == LAST_TICK);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (in_idle),
    .enable (!in_idle),
    .start  (accept),
    .mute   (mute),
    .tick   (o_baud_tick),
    .wrap   (wrap)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      o_ready      <= 1'b1;
      o_busy       <= 1'b0;
      o_load       <= 1'b0;
      o_load_data  <= '0;
      o_frame_done <= 1'b0;
    end else begin
      o_load <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state       <= LOAD;
            bit_cnt     <= '0;
            o_ready     <= 1'b0;
            o_busy      <= 1'b1;
            o_load      <= 1'b1;
            o_load_data <= parity9(i_data, PARITY_ODD);
          end
        end
        LOAD: begin
          state <= SHIFT;
        end
        SHIFT: begin
          if (wrap) begin
            bit_cnt <= bit_cnt + 4'd1;
            if ((bit_cnt + 4'd1) == FIRST_STOP_TICK) begin
              state <= STOP;
            end
          end
        end
        STOP: begin
          if (o_frame_done) begin
            state        <= IDLE;
            o_frame_done <= 1'b0;
            o_ready      <= 1'b1;
            o_busy       <= 1'b0;
          end else if (wrap) begin
            if (bit_cnt == LAST_TICK) begin
              o_frame_done <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: even and odd parity instances on shared stimulus, frame timing model,
// and a behavioural PISO that reconstructs the serial line.
module tb_uart_tx_ctrl;

  localparam int CPB = 4;
`ifdef UART_TX_TWO_STOP_EN
  localparam int NT = 12;
`else
  localparam int NT = 11;
`endif
  localparam int FRAME = CPB * NT + 1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       i_valid = 1'b0;

  logic       o_ready, o_busy, o_baud_tick, o_load, o_frame_done;
  logic [8:0] o_load_data;
  logic       o_ready_odd, o_busy_odd, o_baud_tick_odd, o_load_odd, o_frame_done_odd;
  logic [8:0] o_load_data_odd;

  always #5 clk = ~clk;

  uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .o_busy(o_busy), .o_baud_tick(o_baud_tick), .o_load(o_load),
    .o_load_data(o_load_data), .o_frame_done(o_frame_done)
  );

  uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b1)) dut_odd (
    .clk(clk), .reset_n(reset_n), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready_odd), .o_busy(o_busy_odd), .o_baud_tick(o_baud_tick_odd), .o_load(o_load_odd),
    .o_load_data(o_load_data_odd), .o_frame_done(o_frame_done_odd)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [8:0] model_ld(input logic [7:0] d, input bit odd);
    int ones;
    ones = $countones(d);
    return {((ones % 2) == 1) != odd, d};
  endfunction

  // Behavioural PISO: start, D0..D7, parity, then ones.
  logic       line;
  logic [9:0] sr;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line <= 1'b1;
      sr   <= '1;
    end else if (o_baud_tick) begin
      if (o_load) begin
        line <= 1'b0;
        sr   <= {1'b1, o_load_data};
      end else begin
        line <= sr[0];
        sr   <= {1'b1, sr[9:1]};
      end
    end
  end

  // Reference model: frame timing as a function of cycles since the accept.
  int         cyc = 0, a = 0, rel = 0, n_acc = 0, tick_cnt = 0;
  bit         act = 1'b0, prev_tick = 1'b0;
  bit         e_tick, e_load, e_done;
  logic [8:0] m_ld_e = '0, m_ld_o = '0;
  int         load_q[$];
  int         done_q[$];
  logic       line_q[$];

  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      act       = 1'b0;
      m_ld_e    = '0;
      m_ld_o    = '0;
      prev_tick = 1'b0;
      line_q.delete();
    end else if (act && (cyc - a) > FRAME) begin
      act = 1'b0;
    end
    rel    = cyc - a;
    e_tick = act && rel >= 1 && ((rel - 1) % CPB == 0) && ((rel - 1) / CPB < NT);
    e_load = act && rel == 1;
    e_done = act && rel == FRAME;
    chk("status", {o_ready, o_busy, o_baud_tick, o_load, o_frame_done},
        {!act, act, e_tick, e_load, e_done});
    chk("status_odd", {o_ready_odd, o_busy_odd, o_baud_tick_odd, o_load_odd, o_frame_done_odd},
        {!act, act, e_tick, e_load, e_done});
    chk("load_data", o_load_data, m_ld_e);
    chk("load_data_odd", o_load_data_odd, m_ld_o);
    if (reset_n) begin
      if (prev_tick) line_q.push_back(line);
      if (o_load) begin
        line_q.delete();
        load_q.push_back(cyc);
        tick_cnt = 0;
      end
      if (o_baud_tick) tick_cnt++;
      if (o_frame_done) done_q.push_back(cyc);
      prev_tick = o_baud_tick;
    end
    if (reset_n && i_valid && !act) begin
      act    = 1'b1;
      a      = cyc;
      n_acc++;
      m_ld_e = model_ld(i_data, 1'b0);
      m_ld_o = model_ld(i_data, 1'b1);
    end
  end

  task automatic wait_accept();
    int n0;
    n0 = n_acc;
    for (int i = 0; i < 200 && n_acc == n0; i++) @(posedge clk);
    chk("accept", n_acc, n0 + 1);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && act; i++) begin
      @(posedge clk);
      #1 i_data = 8'($urandom);
    end
    chk("frame_end", act, 0);
  endtask

  task automatic send_frame(input logic [7:0] d);
    i_data  = d;
    i_valid = 1'b1;
    wait_accept();
    i_valid = 1'b0;
    i_data  = 8'($urandom);
    wait_idle();
  endtask

  task automatic check_frame(input logic [7:0] d);
    logic eb;
    chk("tick_count", tick_cnt, NT);
    chk("line_len", line_q.size(), NT);
    chk("line_idle", line, 1'b1);
    chk("done_seen", (done_q.size() > 0 && load_q.size() > 0), 1'b1);
    if (done_q.size() > 0 && load_q.size() > 0) chk("done_latency", done_q[$] - load_q[$], CPB * NT);
    for (int k = 0; k < NT && k < line_q.size(); k++) begin
      if (k == 0) eb = 1'b0;
      else if (k <= 8) eb = d[k-1];
      else if (k == 9) eb = ($countones(d) % 2) == 1;
      else eb = 1'b1;
      chk("line_bit", line_q[k], eb);
    end
  endtask

  initial begin
    logic [7:0] d;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;

    send_frame(8'hA5);
    chk("a5_even", o_load_data, 9'h0A5);
    chk("a5_odd", o_load_data_odd, 9'h1A5);
    check_frame(8'hA5);

    send_frame(8'h00);
    chk("00_odd", o_load_data_odd, 9'h100);
    chk("00_even", o_load_data, 9'h000);
    send_frame(8'h01);
    chk("01_odd", o_load_data_odd, 9'h001);
    chk("01_even", o_load_data, 9'h101);

    send_frame(8'hFF);
    check_frame(8'hFF);

    // Back-to-back with valid held high across the frame boundary.
    i_data  = 8'h55;
    i_valid = 1'b1;
    wait_accept();
    i_data = 8'hAA;
    wait_accept();
    i_valid = 1'b0;
    wait_idle();
    chk("b2b_len", (load_q.size() >= 2 && done_q.size() >= 2), 1'b1);
    if (load_q.size() >= 2 && done_q.size() >= 2) begin
      chk("b2b_gap", load_q[$] - load_q[$-1], CPB * NT + 2);
      chk("b2b_after_done", load_q[$] - done_q[$-1], 2);
    end
    check_frame(8'hAA);

    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #1 d = 8'($urandom);
      send_frame(d);
      check_frame(d);
    end

    // Reset during the tick that opens bit period 5.
    i_data  = 8'($urandom);
    i_valid = 1'b1;
    wait_accept();
    i_valid = 1'b0;
    for (int i = 0; i < 100 && !(act && (cyc - a) == 1 + CPB * 5); i++) begin
      @(negedge clk);
      #1;
    end
    chk("tick5_reached", act && (cyc - a) == 1 + CPB * 5, 1'b1);
    chk("tick5_dut", o_baud_tick, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("rst_ready", o_ready, 1'b1);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_tick", o_baud_tick, 1'b0);
    chk("rst_load", o_load, 1'b0);
    chk("rst_done", o_frame_done, 1'b0);
    chk("rst_ld", o_load_data, 9'h000);
    chk("rst_line", line, 1'b1);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send_frame(8'h3C);
    check_frame(8'h3C);

    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
